iir_par_tdm: RTL
================

Name: iir_par_tdm

Overview:
- Parametrised, multi-channel first-order recursive filter.
- Successor to the two-path half-rate shift-add IIR: channel-interleaved input at full clock rate, runtime shift-add coefficients, per-channel state, valid tagging and synchronous state clear.
- Each channel computes y[n] = x[n] + B(x[n-1]) + A(y[n-1]).
  - B and A are each the sum of up to two arithmetic right shifts, so no multipliers are used.
- Sits between the front-end decimator and the channel demux.

Parameters:
- W, 16, sample width in bits, two's complement (W ≥ 8).
- CH, 4, number of interleaved channels (power of two, ≥ 2).
- CW, 2, channel-tag width; must equal log2(CH).

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  synchronous, active-low reset.
- clr  in  1  synchronous clear of all channel state and the pipeline.
- in_valid  in  1  input sample qualifier.
- in_ch  in  CW  channel tag of the input sample.
- x_in  in  W  input sample.
- kb1, kb2  in  4 each  feed-forward shift amounts; 0 disables that term.
- ka1, ka2  in  4 each  feedback shift amounts; 0 disables that term.
- out_valid  out  1  output sample qualifier.
- out_ch  out  CW  channel tag of the output sample.
- y_out  out  W  filtered sample.
- out_sat  out  1  pulses high with out_valid when the sample was clamped.

Behaviour:
- Reset (reset=0 at a clock edge) zeroes:
  - out_valid, out_ch, y_out, out_sat
  - both pipeline stages
  - all per-channel state x_prev[c] and y_prev[c]
- Stage 1 (input edge): on in_valid=1, register x_in and in_ch and set s1_valid. When in_valid=0, s1_valid is cleared.
- Stage 2 (combinational, then output edge):
  - Read x_prev[ch] and y_prev[ch] combinationally from the register array.
  - Compute sum = x + (xp>>>kb1) + (xp>>>kb2) + (yp>>>ka1) + (yp>>>ka2).
  - Terms whose shift is 0 contribute 0. Shift >>> is arithmetic (floor toward −inf), for shifts 1..15.
  - Sum is held at width W+3 with no intermediate overflow.
  - The result is reduced to W bits (see Optional Feature) and registered to y_out, out_ch and out_valid=1.
  - On the same edge, x_prev[ch] is set to x and y_prev[ch] to the reduced result.
- Latency: a sample accepted at edge t appears at edge t+1 (out_valid high for the cycle after t+1); 2 register stages.
- Throughput: one sample per cycle, any channel order.
- Same channel on consecutive cycles must match sequential evaluation exactly. The stage-2 read of an updated state is guaranteed because the state write and the output register share an edge. Add no extra bypass that would break this.
- When stage 2 is empty, out_valid=0 on the next cycle. y_out, out_ch and state hold their values.
- clr=1 at an edge:
  - all x_prev and y_prev go to 0
  - s1_valid and out_valid go to 0
  - the sample in stage 2 is discarded and not written to state
  - a sample presented with in_valid in the clr cycle is dropped
- clr and reset together: reset wins; the result is identical.
- Coefficients are sampled combinationally in stage 2. A change takes effect on the next stage-2 computation; the bench keeps them stable during traffic.
- Filter stability (gain of A < 1) is the user's responsibility and is not checked.

Optional Feature:
- Macro: IIR_TDM_SAT_EN.
- Defined:
  - sum is clamped to [−2^(W−1), 2^(W−1)−1]
  - out_sat=1 on clamp
  - the clamped value is stored as y_prev
- Undefined:
  - sum is truncated to its low W bits (wrap)
  - out_sat is tied to 0

Test Plan:
- Impulse, W=16 CH=4, kb1=1 ka1=1 other shifts 0, ch0 samples 1024,0,0,0 → y_out 1024,1024,512,256, out_ch=0, one cycle after each input.
- Interleave: ch0 impulse 1024 and ch2 impulse −2048 alternated with zeros on ch0/ch2 → ch0 1024,1024,512; ch2 −2048,−2048,−1024; no cross-channel leakage.
- Back-to-back same channel: ch3 samples 100,100,100 on consecutive cycles, ka1=1 → 100,150,175.
- Saturation: ch1 32767 twice, ka1=1:
  - with IIR_TDM_SAT_EN → 32767 then 32767, out_sat=0 then 1
  - without the macro → 32767 then −16386, out_sat=0
- Clear: after the impulse sequence, pulse clr with a sample in stage 2 → no out_valid the next cycle; a subsequent 0 input on ch0 → y_out=0.
- Reset mid-traffic: drop reset low for 1 cycle during a stream → all outputs 0 the next cycle; the first post-reset sample 500 (ka1=1) → 500.

Source files
------------

// File: rtl/iir_par_tdm.sv
// Purpose : channel-interleaved first-order shift-add IIR, y = x + B(x[n-1]) + A(y[n-1]) per channel.
// Latency : sample registered at edge t is presented at y_out after edge t+1 (two register stages).
// Backpressure: none; accepts one sample per cycle in any channel order. Optional clamp: IIR_TDM_SAT_EN.
module iir_par_tdm #(
    parameter int W  = 16,
    parameter int CH = 4,
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          in_valid,
    input  logic [CW-1:0] in_ch,
    input  logic [W-1:0]  x_in,
    input  logic [3:0]    kb1,
    input  logic [3:0]    kb2,
    input  logic [3:0]    ka1,
    input  logic [3:0]    ka2,
    output logic          out_valid,
    output logic [CW-1:0] out_ch,
    output logic [W-1:0]  y_out,
    output logic          out_sat
);

    // Five W-bit terms fit in W+3 bits without overflow.
    localparam int SW = W + 3;

    // Arithmetic right shift where a shift of zero disables the term.
    function automatic logic signed [SW-1:0] shr_term(input logic signed [SW-1:0] v,
                                                      input logic [3:0] k);
        logic signed [SW-1:0] r;
        r = '0;
        if (k != 4'd0) begin
            r = v >>> k;
        end
        return r;
    endfunction

    // Sign-extend a W-bit sample into the wide accumulator format.
    function automatic logic signed [SW-1:0] sext(input logic [W-1:0] v);
        return {{3{v[W-1]}}, v};
    endfunction

    // Stage 1 registers
    logic          s1_valid_q, s1_valid_d;
    logic [W-1:0]  s1_x_q,     s1_x_d;
    logic [CW-1:0] s1_ch_q,    s1_ch_d;

    // Output registers
    logic          out_valid_q, out_valid_d;
    logic [CW-1:0] out_ch_q,    out_ch_d;
    logic [W-1:0]  y_out_q,     y_out_d;
    logic          out_sat_q,   out_sat_d;

    // Per-channel filter state
    logic [W-1:0]  x_prev_q [CH];
    logic [W-1:0]  x_prev_d [CH];
    logic [W-1:0]  y_prev_q [CH];
    logic [W-1:0]  y_prev_d [CH];

    // Stage 2 datapath
    logic signed [SW-1:0] x_ext;
    logic signed [SW-1:0] xp_ext;
    logic signed [SW-1:0] yp_ext;
    logic signed [SW-1:0] sum;
    logic [W-1:0]         y_red;
    logic                 sat_flag;

    // Stage 1: capture the incoming sample; a sample arriving with clr is dropped.
    always_comb begin
        s1_valid_d = in_valid && !clr;
        s1_x_d     = s1_x_q;
        s1_ch_d    = s1_ch_q;
        if (in_valid) begin
            s1_x_d  = x_in;
            s1_ch_d = in_ch;
        end
    end

    // Stage 2: read channel state and form the full-precision shift-add sum.
    always_comb begin
        x_ext  = sext(s1_x_q);
        xp_ext = sext(x_prev_q[s1_ch_q]);
        yp_ext = sext(y_prev_q[s1_ch_q]);
        sum    = x_ext
               + shr_term(xp_ext, kb1) + shr_term(xp_ext, kb2)
               + shr_term(yp_ext, ka1) + shr_term(yp_ext, ka2);
    end

`ifdef IIR_TDM_SAT_EN
    // Clamp to the W-bit range; in range exactly when the top four bits agree.
    always_comb begin
        sat_flag = !((&sum[SW-1:W-1]) || !(|sum[SW-1:W-1]));
        y_red    = sum[W-1:0];
        if (sat_flag) begin
            y_red = sum[SW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end
`else
    // Wrap to the low W bits; the guard bits are intentionally discarded.
    logic sum_unused;
    always_comb begin
        y_red      = sum[W-1:0];
        sat_flag   = 1'b0;
        sum_unused = ^sum[SW-1:W];
    end
`endif

    // Output and state update: both land on the same edge so a back-to-back
    // sample on the same channel reads the freshly written state.
    always_comb begin
        out_valid_d = 1'b0;
        out_ch_d    = out_ch_q;
        y_out_d     = y_out_q;
        out_sat_d   = 1'b0;
        for (int c = 0; c < CH; c++) begin
            x_prev_d[c] = x_prev_q[c];
            y_prev_d[c] = y_prev_q[c];
        end
        if (clr) begin
            for (int c = 0; c < CH; c++) begin
                x_prev_d[c] = '0;
                y_prev_d[c] = '0;
            end
        end else if (s1_valid_q) begin
            out_valid_d        = 1'b1;
            out_ch_d           = s1_ch_q;
            y_out_d            = y_red;
            out_sat_d          = sat_flag;
            x_prev_d[s1_ch_q]  = s1_x_q;
            y_prev_d[s1_ch_q]  = y_red;
        end
    end

    // Register all state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            s1_x_q      <= '0;
            s1_ch_q     <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            y_out_q     <= '0;
            out_sat_q   <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                x_prev_q[c] <= '0;
                y_prev_q[c] <= '0;
            end
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_x_q      <= s1_x_d;
            s1_ch_q     <= s1_ch_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            y_out_q     <= y_out_d;
            out_sat_q   <= out_sat_d;
            for (int c = 0; c < CH; c++) begin
                x_prev_q[c] <= x_prev_d[c];
                y_prev_q[c] <= y_prev_d[c];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign y_out     = y_out_q;
    assign out_sat   = out_sat_q;

endmodule
